four_ask_demod: RTL and testbench

FOUR_ASK_DEMOD -- requirements
Module: four_ask_demod

---
 rtl/four_ask_demod_pkg.sv | 45 ++++
 rtl/pwm_width_meter.sv | 109 ++++++++++
 rtl/four_ask_demod.sv | 118 +++++++++++
 tb/tb_four_ask_demod.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/four_ask_demod_pkg.sv
// Shared types and constants for the 4-ASK PWM demodulator and its matching modulator.
package four_ask_demod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  typedef logic [1:0] sym_t;

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned CNT_MAX  = 1023;
  localparam int unsigned HIGH_MAX = 150;

  localparam int unsigned PERIOD_NOM         = 500;
  localparam int unsigned TOL_NOM            = 8;
  localparam int unsigned SYMBOL_PERIODS_NOM = 4;
  localparam int unsigned BIT_CYCLES_NOM     = 1000;
  localparam int unsigned TH1_NOM            = 34;
  localparam int unsigned TH2_NOM            = 64;
  localparam int unsigned TH3_NOM            = 98;

  // Modulator high times per symbol; thresholds sit between neighbouring duties.
  localparam int unsigned DUTY_00 = 22;
  localparam int unsigned DUTY_01 = 47;
  localparam int unsigned DUTY_10 = 82;
  localparam int unsigned DUTY_11 = 115;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(CNT_MAX)) ? v : v + CNT_W'(1);
  endfunction

  // A high time equal to a threshold belongs to the upper class.
  function automatic sym_t classify(input logic [CNT_W-1:0] high,
                                    input int unsigned th1,
                                    input int unsigned th2,
                                    input int unsigned th3);
    if (32'(high) < th1) return sym_t'(2'b00);
    if (32'(high) < th2) return sym_t'(2'b01);
    if (32'(high) < th3) return sym_t'(2'b10);
    return sym_t'(2'b11);
  endfunction

endpackage

// File: rtl/pwm_width_meter.sv
// Synchronizes the PWM line and measures period and high time of each carrier cycle.
module pwm_width_meter
  import four_ask_demod_pkg::*;
#(
  parameter int unsigned PERIOD = PERIOD_NOM,
  parameter int unsigned TOL    = TOL_NOM,
  parameter int unsigned TH1    = TH1_NOM,
  parameter int unsigned TH2    = TH2_NOM,
  parameter int unsigned TH3    = TH3_NOM
) (
  input  logic clk,
  input  logic rst,
  input  logic modulated,
  output logic period_done_c,
  output logic period_ok_c,
  output sym_t period_class_c,
  output logic timeout_c
);

  localparam logic [CNT_W-1:0] P_MIN    = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] P_MAX    = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] T_OUT    = CNT_W'(PERIOD + PERIOD / 4);

  logic             sync1;
  logic             sync2;
  logic             sync_d;
  logic             rise_c;
  logic             fall_c;
  logic             timeout_hit;
  state_t           state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;

  assign rise_c      = sync2 & ~sync_d;
  assign fall_c      = ~sync2 & sync_d;
  assign timeout_hit = (period_cnt >= T_OUT);

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= modulated;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  // Measurement FSM: a period runs from one rising edge to the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise_c) begin
            state      <= ST_HIGH;
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (fall_c) begin
            state      <= ST_LOW;
            period_cnt <= sat_inc(period_cnt);
          end else if (timeout_hit) begin
            state      <= ST_IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
          end else begin
            period_cnt <= sat_inc(period_cnt);
            high_cnt   <= sat_inc(high_cnt);
          end
        end
        ST_LOW: begin
          if (rise_c) begin
            state      <= ST_HIGH;
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
          end else if (timeout_hit) begin
            state      <= ST_IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
          end else begin
            period_cnt <= sat_inc(period_cnt);
          end
        end
        default: begin
          state      <= ST_IDLE;
          period_cnt <= '0;
          high_cnt   <= '0;
        end
      endcase
    end
  end

  // Period verdict is presented in the cycle of the closing rising edge.
  assign period_done_c  = (state == ST_LOW) & rise_c;
  assign period_ok_c    = (period_cnt >= P_MIN) && (period_cnt <= P_MAX) && (high_cnt <= H_MAX);
  assign period_class_c = classify(high_cnt, TH1, TH2, TH3);
  assign timeout_c      = timeout_hit &
                          (((state == ST_HIGH) & ~fall_c) | ((state == ST_LOW) & ~rise_c));

endmodule

// File: rtl/four_ask_demod.sv
// 4-ASK PWM demodulator: lock tracking, symbol accumulation and MSB-first serial output.
module four_ask_demod
  import four_ask_demod_pkg::*;
#(
  parameter int unsigned PERIOD         = PERIOD_NOM,
  parameter int unsigned TOL            = TOL_NOM,
  parameter int unsigned SYMBOL_PERIODS = SYMBOL_PERIODS_NOM,
  parameter int unsigned BIT_CYCLES     = BIT_CYCLES_NOM,
  parameter int unsigned TH1            = TH1_NOM,
  parameter int unsigned TH2            = TH2_NOM,
  parameter int unsigned TH3            = TH3_NOM
) (
  input  logic clk,
  input  logic rst,
  input  logic modulated,
  output sym_t sym,
  output logic sym_valid,
  output logic sym_err,
  output logic message,
  output logic lock
);

  localparam int unsigned SYM_W = $clog2(SYMBOL_PERIODS + 1);
  localparam int unsigned BIT_W = $clog2(BIT_CYCLES + 1);

  logic             period_done_c;
  logic             period_ok_c;
  logic             timeout_c;
  sym_t             period_class_c;
  logic [1:0]       run_cnt;
  logic [SYM_W-1:0] sym_cnt;
  sym_t             first_class;
  logic             diff_seen;
  logic             sym_fire_c;
  logic             sym_err_c;
  logic             ser_busy;
  logic [BIT_W-1:0] bit_cnt;

  pwm_width_meter #(
    .PERIOD (PERIOD),
    .TOL    (TOL),
    .TH1    (TH1),
    .TH2    (TH2),
    .TH3    (TH3)
  ) u_meter (
    .clk            (clk),
    .rst            (rst),
    .modulated      (modulated),
    .period_done_c  (period_done_c),
    .period_ok_c    (period_ok_c),
    .period_class_c (period_class_c),
    .timeout_c      (timeout_c)
  );

  assign sym_fire_c = period_done_c & period_ok_c & lock &
                      (sym_cnt == SYM_W'(SYMBOL_PERIODS - 1));
  assign sym_err_c  = (sym_cnt == '0) ? 1'b0 : (diff_seen | (period_class_c != first_class));

  // Lock and symbol accumulation; only periods seen while already locked count.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock        <= 1'b0;
      run_cnt     <= '0;
      sym_cnt     <= '0;
      first_class <= '0;
      diff_seen   <= 1'b0;
      sym         <= '0;
      sym_valid   <= 1'b0;
      sym_err     <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      sym_err   <= 1'b0;
      if (timeout_c || (period_done_c && !period_ok_c)) begin
        lock      <= 1'b0;
        run_cnt   <= '0;
        sym_cnt   <= '0;
        diff_seen <= 1'b0;
      end else if (period_done_c) begin
        if (run_cnt != 2'd2) run_cnt <= run_cnt + 2'd1;
        if (run_cnt != 2'd0) lock <= 1'b1;
        if (lock) begin
          if (sym_fire_c) begin
            sym       <= period_class_c;
            sym_valid <= 1'b1;
            sym_err   <= sym_err_c;
            sym_cnt   <= '0;
            diff_seen <= 1'b0;
          end else begin
            if (sym_cnt == '0) first_class <= period_class_c;
            else if (period_class_c != first_class) diff_seen <= 1'b1;
            sym_cnt <= sym_cnt + SYM_W'(1);
          end
        end
      end
    end
  end

  // Serializer: MSB for BIT_CYCLES cycles, then LSB held; a new symbol restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      message  <= 1'b0;
      ser_busy <= 1'b0;
      bit_cnt  <= '0;
    end else if (sym_fire_c) begin
      message  <= period_class_c[1];
      ser_busy <= 1'b1;
      bit_cnt  <= BIT_W'(1);
    end else if (ser_busy) begin
      if (bit_cnt == BIT_W'(BIT_CYCLES)) begin
        message  <= sym[0];
        ser_busy <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_four_ask_demod.sv
// Self-checking bench for four_ask_demod against a period-list reference model.
`timescale 1ns/1ps
module tb_four_ask_demod;
  import four_ask_demod_pkg::*;

  localparam int PER     = 500;
  localparam int TOLR    = 8;
  localparam int SYMP    = 4;
  localparam int BITC    = 1000;
  localparam int T1      = 34;
  localparam int T2      = 64;
  localparam int T3      = 98;
  localparam int TIMEOUT = PER + PER / 4;

  logic clk = 1'b0;
  logic rst;
  logic modulated;
  sym_t sym;
  logic sym_valid;
  logic sym_err;
  logic message;
  logic lock;

  four_ask_demod #(
    .PERIOD(PER), .TOL(TOLR), .SYMBOL_PERIODS(SYMP), .BIT_CYCLES(BITC),
    .TH1(T1), .TH2(T2), .TH3(T3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .modulated (modulated),
    .sym       (sym),
    .sym_valid (sym_valid),
    .sym_err   (sym_err),
    .message   (message),
    .lock      (lock)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic [1:0] s; logic e; } sym_rec_t;
  sym_rec_t   exp_q[$];
  sym_rec_t   obs_q[$];
  logic [1:0] obs_msg_q[$];

  // Monitor: record every symbol and the serial bits shown for it.
  sym_rec_t mrec;
  int       mk = 0;
  logic     mhi = 1'b0;
  bit       mon = 1'b0;
  always @(negedge clk) begin
    if (rst) mon = 1'b0;
    else begin
      if (mon) begin
        mk++;
        if (mk == BITC - 1) mhi = message;
        else if (mk == BITC) begin
          obs_msg_q.push_back({mhi, message});
          mon = 1'b0;
        end
      end
      if (sym_valid) begin
        mrec.s = sym;
        mrec.e = sym_err;
        obs_q.push_back(mrec);
        mon = 1'b1;
        mk  = 0;
      end
    end
  end

  // Reference model: works on whole periods (high time, total length).
  bit       p_on = 1'b0;
  int       p_high = 0;
  int       p_tot = 0;
  int       m_run = 0;
  bit       m_lock = 1'b0;
  int       m_cnt = 0;
  logic [1:0] m_first = 2'b00;
  bit       m_err = 1'b0;
  sym_rec_t erec;

  function automatic logic [1:0] m_class(input int h);
    if (h < T1) return 2'b00;
    if (h < T2) return 2'b01;
    if (h < T3) return 2'b10;
    return 2'b11;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_lock = 1'b0; m_cnt = 0; m_err = 1'b0;
  endfunction

  function automatic void model_eval(input int h, input int t);
    logic [1:0] c;
    if (t >= TIMEOUT || t < PER - TOLR || t > PER + TOLR || h > 150) model_reset();
    else begin
      c = m_class(h);
      if (m_lock) begin
        if (m_cnt == 0) begin m_first = c; m_err = 1'b0; end
        else if (c != m_first) m_err = 1'b1;
        m_cnt++;
        if (m_cnt == SYMP) begin
          erec.s = c; erec.e = m_err;
          exp_q.push_back(erec);
          m_cnt = 0;
        end
      end
      if (m_run < 2) m_run++;
      if (m_run >= 2) m_lock = 1'b1;
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic drive_period(input int h, input int t);
    if (p_on) model_eval(p_high, p_tot);
    p_on = 1'b1; p_high = h; p_tot = t;
    modulated = 1'b1; step(h);
    modulated = 1'b0; step(t - h);
  endtask

  task automatic drive_idle(input int n);
    modulated = 1'b0;
    step(n);
    if (p_on) begin
      p_tot += n;
      if (p_tot >= TIMEOUT) begin model_reset(); p_on = 1'b0; end
    end
  endtask

  task automatic clear_queues();
    exp_q.delete(); obs_q.delete(); obs_msg_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; modulated = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);
    n_cmp++; if (sym !== 2'b00)   begin n_bad++; $display("FAIL reset sym: got %b want 00", sym); end
    n_cmp++; if (sym_valid !== 1'b0) begin n_bad++; $display("FAIL reset sym_valid: got %b want 0", sym_valid); end
    n_cmp++; if (sym_err !== 1'b0) begin n_bad++; $display("FAIL reset sym_err: got %b want 0", sym_err); end
    n_cmp++; if (message !== 1'b0) begin n_bad++; $display("FAIL reset message: got %b want 0", message); end
    n_cmp++; if (lock !== 1'b0)    begin n_bad++; $display("FAIL reset lock: got %b want 0", lock); end
  endtask

  task automatic test_sym00();
    for (int i = 0; i < 7; i++) begin
      drive_period(DUTY_00, PER);
      n_cmp++; if (lock !== m_lock) begin n_bad++; $display("FAIL sym00 lock[%0d]: got %b want %b", i, lock, m_lock); end
    end
    drive_idle(1200);
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL sym00 count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_cmp++; if (obs_q[0] !== 3'b000) begin n_bad++; $display("FAIL sym00 sym/err: got %b want 000", obs_q[0]); end
    end
    n_cmp++; if (obs_msg_q.size() != 1) begin n_bad++; $display("FAIL sym00 msg count: got %0d want 1", obs_msg_q.size()); end
    else begin
      n_cmp++; if (obs_msg_q[0] !== 2'b00) begin n_bad++; $display("FAIL sym00 message: got %b want 00", obs_msg_q[0]); end
    end
    clear_queues();
  endtask

  task automatic test_sym11_10();
    logic [2:0] want [2];
    logic [1:0] wmsg [2];
    want[0] = 3'b110; want[1] = 3'b100;
    wmsg[0] = 2'b11;  wmsg[1] = 2'b10;
    for (int i = 0; i < 11; i++) begin
      drive_period((i < 6) ? DUTY_11 : DUTY_10, PER);
      n_cmp++; if (lock !== m_lock) begin n_bad++; $display("FAIL sym11_10 lock[%0d]: got %b want %b", i, lock, m_lock); end
    end
    drive_idle(1200);
    n_cmp++; if (obs_q.size() != 2) begin n_bad++; $display("FAIL sym11_10 count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== want[i]) begin n_bad++; $display("FAIL sym11_10 sym[%0d]: got %b want %b", i, obs_q[i], want[i]); end
    end
    for (int i = 0; i < 2 && i < obs_msg_q.size(); i++) begin
      n_cmp++; if (obs_msg_q[i] !== wmsg[i]) begin n_bad++; $display("FAIL sym11_10 message[%0d]: got %b want %b", i, obs_msg_q[i], wmsg[i]); end
    end
    clear_queues();
  endtask

  task automatic test_err();
    int hs [7];
    hs = '{DUTY_01, DUTY_01, DUTY_01, DUTY_01, DUTY_10, DUTY_01, DUTY_01};
    for (int i = 0; i < 7; i++) begin
      drive_period(hs[i], PER);
      n_cmp++; if (lock !== m_lock) begin n_bad++; $display("FAIL err lock[%0d]: got %b want %b", i, lock, m_lock); end
    end
    drive_idle(1200);
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL err count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_cmp++; if (obs_q[0] !== 3'b011) begin n_bad++; $display("FAIL err sym/err: got %b want 011", obs_q[0]); end
    end
    clear_queues();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 3; i++) drive_period(DUTY_10, PER);
    n_cmp++; if (lock !== 1'b1) begin n_bad++; $display("FAIL timeout prelock: got %b want 1", lock); end
    drive_idle(140);
    n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL timeout lock: got %b want 0", lock); end
    n_cmp++; if (dut.u_meter.state !== ST_IDLE) begin n_bad++; $display("FAIL timeout state: got %0d want %0d", dut.u_meter.state, ST_IDLE); end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL timeout sym_valid count: got %0d want 0", obs_q.size()); end
    drive_idle(200);
    clear_queues();
  endtask

  task automatic test_bad_period();
    int hs [11];
    int ts [11];
    hs = '{47, 47, 47, 47, 47, 47, 98, 115, 115, 115, 47};
    ts = '{PER, PER, PER, 520, PER, PER, PER, PER, PER, PER, PER};
    for (int i = 0; i < 11; i++) begin
      drive_period(hs[i], ts[i]);
      n_cmp++; if (lock !== m_lock) begin n_bad++; $display("FAIL bad_period lock[%0d]: got %b want %b", i, lock, m_lock); end
    end
    drive_idle(1200);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bad_period count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bad_period sym[%0d]: got %b want %b", i, obs_q[i], exp_q[i]); end
    end
    clear_queues();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) drive_period(DUTY_11, PER);
    if (p_on) model_eval(p_high, p_tot);
    p_on = 1'b0;
    modulated = 1'b1;
    step(40);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    model_reset();
    n_cmp++; if (sym !== 2'b00)      begin n_bad++; $display("FAIL reset_mid sym: got %b want 00", sym); end
    n_cmp++; if (sym_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mid sym_valid: got %b want 0", sym_valid); end
    n_cmp++; if (sym_err !== 1'b0)   begin n_bad++; $display("FAIL reset_mid sym_err: got %b want 0", sym_err); end
    n_cmp++; if (message !== 1'b0)   begin n_bad++; $display("FAIL reset_mid message: got %b want 0", message); end
    n_cmp++; if (lock !== 1'b0)      begin n_bad++; $display("FAIL reset_mid lock: got %b want 0", lock); end
    step(75);
    modulated = 1'b0;
    step(385);
    for (int i = 0; i < 7; i++) begin
      drive_period(DUTY_10, PER);
      n_cmp++; if (lock !== m_lock) begin n_bad++; $display("FAIL reset_mid lock[%0d]: got %b want %b", i, lock, m_lock); end
    end
    drive_idle(1200);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL reset_mid count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL reset_mid sym[%0d]: got %b want %b", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (obs_msg_q.size() != 1) begin n_bad++; $display("FAIL reset_mid msg count: got %0d want 1", obs_msg_q.size()); end
    else begin
      n_cmp++; if (obs_msg_q[0] !== 2'b10) begin n_bad++; $display("FAIL reset_mid message: got %b want 10", obs_msg_q[0]); end
    end
    clear_queues();
  endtask

  task automatic test_boundaries();
    int hs [20];
    int ts [20];
    hs = '{22, 22, 33, 34, 63, 64, 97, 98, 150, 150, 151, 47, 47, 47, 47, 82, 82, 82, 82, 82};
    ts = '{500, 500, 500, 492, 508, 500, 492, 508, 500, 500, 500, 491, 500, 509, 500, 500, 500, 500, 500, 500};
    for (int i = 0; i < 20; i++) begin
      drive_period(hs[i], ts[i]);
      n_cmp++; if (lock !== m_lock) begin n_bad++; $display("FAIL boundaries lock[%0d]: got %b want %b", i, lock, m_lock); end
    end
    drive_idle(1200);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL boundaries count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL boundaries sym[%0d]: got %b want %b", i, obs_q[i], exp_q[i]); end
    end
    clear_queues();
  endtask

  task automatic test_random();
    int h;
    int t;
    for (int i = 0; i < 50; i++) begin
      h = ($urandom_range(0, 15) == 0) ? int'($urandom_range(151, 170)) : int'($urandom_range(10, 150));
      t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(470, 530)) : int'($urandom_range(PER - TOLR, PER + TOLR));
      drive_period(h, t);
      n_cmp++; if (lock !== m_lock) begin n_bad++; $display("FAIL random lock[%0d] h=%0d t=%0d: got %b want %b", i, h, t, lock, m_lock); end
    end
    drive_idle(1200);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL random sym[%0d]: got %b want %b", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < exp_q.size() && i < obs_msg_q.size(); i++) begin
      n_cmp++; if (obs_msg_q[i] !== exp_q[i].s) begin n_bad++; $display("FAIL random message[%0d]: got %b want %b", i, obs_msg_q[i], exp_q[i].s); end
    end
    clear_queues();
  endtask

  initial begin
    rst = 1'b1;
    modulated = 1'b0;
    test_reset();
    test_sym00();
    test_sym11_10();
    test_err();
    test_timeout();
    test_bad_period();
    test_reset_mid();
    test_boundaries();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
